// File: rtl/agc_datapath.sv
// AGC register/ALU datapath: holds A, B, G, LP, Q, X, Y, Z and executes the
// load pulses issued by the sequencing FSM. No sequencing of its own.
module agc_datapath #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_wr,
    input  logic              lp_wr,
    input  logic              g_wr,
    input  logic              q_wr,
    input  logic              b_wr,
    input  logic              a_wr,
    input  logic              y_wr,
    input  logic              x_wr,
    input  logic              z_wr,
    input  logic              maddr_mux,
    input  logic              mdata_mux,
    input  logic              lp_mux,
    input  logic              g_mux,
    input  logic              b_mux,
    input  logic [1:0]        q_mux,
    input  logic [1:0]        a_mux,
    input  logic [1:0]        x_mux,
    input  logic [1:0]        z_mux,
    input  logic [2:0]        y_mux,
    input  logic [2:0]        alu_op,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_we,
    output logic [2:0]        opcode,
    output logic [1:0]        qc,
    output logic [WIDTH-1:0]  pc
);

    logic [WIDTH-1:0]   r_a, r_b, r_g, r_lp, r_q, r_x, r_y, r_z;
    logic [WIDTH-1:0]   w_alu_y;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_den;
    logic [WIDTH-1:0]   w_b_addr;
    logic [WIDTH-1:0]   w_q_src, w_a_src, w_x_src, w_z_src, w_y_src;

    assign w_prod   = {{WIDTH{1'b0}}, r_x} * {{WIDTH{1'b0}}, r_y};
    // Divisor forced nonzero so the divider never sees 0; the Y==0 results are selected below.
    assign w_den    = (r_y == '0) ? WIDTH'(1) : r_y;
    assign w_b_addr = {{(WIDTH-ADDR_W){1'b0}}, r_b[ADDR_W-1:0]};

    always_comb begin
        w_alu_y = r_x;
        case (alu_op)
            3'd0: w_alu_y = r_x + r_y;
            3'd1: w_alu_y = r_x - r_y;
            3'd2: w_alu_y = r_x & r_y;
            3'd3: w_alu_y = w_prod[WIDTH-1:0];
            3'd4: w_alu_y = w_prod[2*WIDTH-1:WIDTH];
            3'd5: w_alu_y = (r_y == '0) ? r_x : (r_x % w_den);
            3'd6: w_alu_y = (r_y == '0) ? '1 : (r_x / w_den);
            default: w_alu_y = r_x;
        endcase
    end

    always_comb begin
        w_q_src = r_a;
        w_a_src = mem_rdata;
        w_x_src = mem_rdata;
        w_z_src = mem_rdata;
        w_y_src = '0;
        case (q_mux)
            2'd0: w_q_src = r_a;
            2'd1: w_q_src = w_alu_y;
            2'd2: w_q_src = r_z;
            default: w_q_src = mem_rdata;
        endcase
        case (a_mux)
            2'd0: w_a_src = mem_rdata;
            2'd1: w_a_src = w_alu_y;
            2'd2: w_a_src = ~r_g;
            default: w_a_src = r_g;
        endcase
        case (x_mux)
            2'd0: w_x_src = mem_rdata;
            2'd1: w_x_src = r_z;
            2'd2: w_x_src = r_a;
            default: w_x_src = r_b;
        endcase
        case (z_mux)
            2'd0: w_z_src = mem_rdata;
            2'd1: w_z_src = w_alu_y;
            2'd2: w_z_src = w_b_addr;
            default: w_z_src = r_z;
        endcase
        case (y_mux)
            3'd1: w_y_src = r_a;
            3'd2: w_y_src = WIDTH'(1);
            3'd3: w_y_src = r_b;
            3'd4: w_y_src = '1;
            default: w_y_src = '0;
        endcase
    end

    // Register bank: every source reads pre-edge values, reset beats all pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a  <= '0;
            r_b  <= '0;
            r_g  <= '0;
            r_lp <= '0;
            r_q  <= '0;
            r_x  <= '0;
            r_y  <= '0;
            r_z  <= WIDTH'(RESET_PC);
        end else begin
            if (a_wr)  r_a  <= w_a_src;
            if (b_wr)  r_b  <= b_mux  ? w_alu_y : mem_rdata;
            if (g_wr)  r_g  <= g_mux  ? w_alu_y : mem_rdata;
            if (lp_wr) r_lp <= lp_mux ? w_alu_y : mem_rdata;
            if (q_wr)  r_q  <= w_q_src;
            if (x_wr)  r_x  <= w_x_src;
            if (y_wr)  r_y  <= w_y_src;
            if (z_wr)  r_z  <= w_z_src;
        end
    end

    assign mem_addr  = maddr_mux ? r_b[ADDR_W-1:0] : r_z[ADDR_W-1:0];
    assign mem_wdata = mdata_mux ? w_alu_y : r_a;
    assign mem_we    = mem_wr & ~reset;
    assign opcode    = r_b[14:12];
    assign qc        = r_b[11:10];
    assign pc        = r_z;

endmodule

// File: tb/tb_agc_datapath.sv
// Scoreboard bench for agc_datapath: expectations are queued as stimulus is
// driven and popped when the datapath result is observed.
module tb_agc_datapath;

    localparam int R_A = 0, R_B = 1, R_G = 2, R_LP = 3, R_Q = 4, R_X = 5, R_Z = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr;
    logic        maddr_mux, mdata_mux, lp_mux, g_mux, b_mux;
    logic [1:0]  q_mux, a_mux, x_mux, z_mux;
    logic [2:0]  y_mux, alu_op;
    logic [15:0] mem_rdata;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [2:0]  opcode;
    logic [1:0]  qc;
    logic [15:0] pc;

    logic [15:0] mem [0:4095] = '{default: '0};
    logic        pk_en = 1'b0;
    logic [11:0] pk_addr = '0;
    logic [15:0] pk_data = '0;

    logic [15:0] sb_q [$];
    logic [15:0] expv;
    int          n_tot = 0;
    int          n_pass = 0;

    agc_datapath #(.WIDTH(16), .ADDR_W(12), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset),
        .mem_wr(mem_wr), .lp_wr(lp_wr), .g_wr(g_wr), .q_wr(q_wr), .b_wr(b_wr),
        .a_wr(a_wr), .y_wr(y_wr), .x_wr(x_wr), .z_wr(z_wr),
        .maddr_mux(maddr_mux), .mdata_mux(mdata_mux), .lp_mux(lp_mux), .g_mux(g_mux),
        .b_mux(b_mux), .q_mux(q_mux), .a_mux(a_mux), .x_mux(x_mux), .z_mux(z_mux),
        .y_mux(y_mux), .alu_op(alu_op), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .opcode(opcode), .qc(qc), .pc(pc)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (pk_en) mem[pk_addr] <= pk_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic clr_ctl();
        {mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr} = '0;
        {maddr_mux, mdata_mux, lp_mux, g_mux, b_mux} = '0;
        q_mux = 0; a_mux = 0; x_mux = 0; z_mux = 0; y_mux = 0; alu_op = 0;
    endtask

    task automatic pulse();
        @(posedge clk); #1;
        clr_ctl();
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        pk_en = 1'b1; pk_addr = a; pk_data = d;
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    // Load a register from memory at the current PC word.
    task automatic ld(input int sel, input logic [15:0] v);
        logic [11:0] a;
        a = pc[11:0];
        poke(a, v);
        case (sel)
            R_A:  a_wr = 1;
            R_B:  b_wr = 1;
            R_G:  g_wr = 1;
            R_LP: lp_wr = 1;
            R_Q:  begin q_wr = 1; q_mux = 2'd3; end
            R_X:  x_wr = 1;
            default: z_wr = 1;
        endcase
        pulse();
    endtask

    task automatic set_y(input logic [15:0] v);
        ld(R_A, v);
        y_mux = 3'd1; y_wr = 1;
        pulse();
    endtask

    task automatic test_reset();
        clr_ctl();
        reset = 1'b1;
        {mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr} = '1;
        {maddr_mux, mdata_mux, lp_mux, g_mux, b_mux} = 5'($urandom_range(0, 31));
        q_mux = 2'($urandom_range(0, 3)); a_mux = 2'($urandom_range(0, 3));
        x_mux = 2'($urandom_range(0, 3)); z_mux = 2'($urandom_range(0, 3));
        y_mux = 3'($urandom_range(0, 7)); alu_op = 3'($urandom_range(0, 7));
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(16'h0);
        n_tot++; expv = sb_q.pop_front();
        if ({15'd0, mem_we} !== expv) $display("FAIL rst_mem_we got=%h exp=%h", mem_we, expv); else n_pass++;
        reset = 1'b0;
        clr_ctl();
        repeat (8) sb_q.push_back(16'h0);
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_a !== expv) $display("FAIL rst_a got=%h exp=%h", dut.r_a, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_b !== expv) $display("FAIL rst_b got=%h exp=%h", dut.r_b, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_g !== expv) $display("FAIL rst_g got=%h exp=%h", dut.r_g, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_lp !== expv) $display("FAIL rst_lp got=%h exp=%h", dut.r_lp, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_q !== expv) $display("FAIL rst_q got=%h exp=%h", dut.r_q, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_x !== expv) $display("FAIL rst_x got=%h exp=%h", dut.r_x, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_y !== expv) $display("FAIL rst_y got=%h exp=%h", dut.r_y, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (pc !== expv) $display("FAIL rst_pc got=%h exp=%h", pc, expv); else n_pass++;
    endtask

    task automatic test_tc();
        ld(R_B, 16'h0123);
        ld(R_Z, 16'h0040);
        sb_q.push_back(16'h0040);
        q_mux = 2'd2; q_wr = 1;
        pulse();
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_q !== expv) $display("FAIL tc_q got=%h exp=%h", dut.r_q, expv); else n_pass++;
        sb_q.push_back(16'h0123); sb_q.push_back(16'h0); sb_q.push_back(16'h0);
        z_mux = 2'd2; z_wr = 1;
        pulse();
        n_tot++; expv = sb_q.pop_front();
        if (pc !== expv) $display("FAIL tc_z got=%h exp=%h", pc, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if ({13'd0, opcode} !== expv) $display("FAIL tc_opcode got=%h exp=%h", opcode, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if ({14'd0, qc} !== expv) $display("FAIL tc_qc got=%h exp=%h", qc, expv); else n_pass++;
    endtask

    task automatic test_ad();
        ld(R_A, 16'h0005);
        ld(R_B, 16'h6010);
        poke(12'h010, 16'h0007);
        sb_q.push_back(16'h0006); sb_q.push_back(16'h0000);
        n_tot++; expv = sb_q.pop_front();
        if ({13'd0, opcode} !== expv) $display("FAIL ad_opcode got=%h exp=%h", opcode, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if ({14'd0, qc} !== expv) $display("FAIL ad_qc got=%h exp=%h", qc, expv); else n_pass++;
        maddr_mux = 1; x_wr = 1; y_mux = 3'd1; y_wr = 1;
        pulse();
        sb_q.push_back(16'h000C);
        alu_op = 3'd0; a_mux = 2'd1; a_wr = 1;
        pulse();
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_a !== expv) $display("FAIL ad_a got=%h exp=%h", dut.r_a, expv); else n_pass++;
        ld(R_Z, 16'h0FFF);
        x_mux = 2'd1; x_wr = 1; y_mux = 3'd2; y_wr = 1;
        pulse();
        sb_q.push_back(16'h1000);
        alu_op = 3'd0; z_mux = 2'd1; z_wr = 1;
        pulse();
        n_tot++; expv = sb_q.pop_front();
        if (pc !== expv) $display("FAIL ad_z_inc got=%h exp=%h", pc, expv); else n_pass++;
    endtask

    task automatic test_mp_dv();
        logic [15:0] xs [3] = '{16'h0300, 16'd100, 16'd9};
        logic [15:0] ys [3] = '{16'h0200, 16'd7, 16'd0};
        logic [15:0] el [3] = '{16'h0000, 16'd2, 16'd9};
        logic [15:0] ea [3] = '{16'h0006, 16'd14, 16'hFFFF};
        for (int i = 0; i < 3; i++) begin
            ld(R_LP, 16'hBEEF);
            set_y(ys[i]);
            ld(R_X, xs[i]);
            sb_q.push_back(el[i]); sb_q.push_back(ea[i]);
            alu_op = (i == 0) ? 3'd3 : 3'd5; lp_mux = 1; lp_wr = 1;
            pulse();
            alu_op = (i == 0) ? 3'd4 : 3'd6; a_mux = 2'd1; a_wr = 1;
            pulse();
            n_tot++; expv = sb_q.pop_front();
            if (dut.r_lp !== expv) $display("FAIL mpdv_lp[%0d] got=%h exp=%h", i, dut.r_lp, expv); else n_pass++;
            n_tot++; expv = sb_q.pop_front();
            if (dut.r_a !== expv) $display("FAIL mpdv_a[%0d] got=%h exp=%h", i, dut.r_a, expv); else n_pass++;
        end
    endtask

    task automatic test_xch();
        ld(R_A, 16'h1111);
        poke(12'h010, 16'h2222);
        sb_q.push_back(16'h2222); sb_q.push_back(16'h1111); sb_q.push_back(16'h2222);
        maddr_mux = 1; g_wr = 1;
        pulse();
        maddr_mux = 1; mem_wr = 1;
        pulse();
        a_mux = 2'd3; a_wr = 1;
        pulse();
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_g !== expv) $display("FAIL xch_g got=%h exp=%h", dut.r_g, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (mem[12'h010] !== expv) $display("FAIL xch_mem got=%h exp=%h", mem[12'h010], expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_a !== expv) $display("FAIL xch_a got=%h exp=%h", dut.r_a, expv); else n_pass++;
        ld(R_G, 16'h0000);
        ld(R_A, 16'h1111);
        poke(12'h010, 16'h2222);
        sb_q.push_back(16'h2222); sb_q.push_back(16'h1111);
        maddr_mux = 1; g_wr = 1; mem_wr = 1;
        pulse();
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_g !== expv) $display("FAIL rbw_g got=%h exp=%h", dut.r_g, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (mem[12'h010] !== expv) $display("FAIL rbw_mem got=%h exp=%h", mem[12'h010], expv); else n_pass++;
    endtask

    task automatic test_cs();
        ld(R_G, 16'h00F0);
        sb_q.push_back(16'hFF0F);
        a_mux = 2'd2; a_wr = 1;
        pulse();
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_a !== expv) $display("FAIL cs_a got=%h exp=%h", dut.r_a, expv); else n_pass++;
        ld(R_X, 16'h0003);
        y_mux = 3'd4; y_wr = 1;
        pulse();
        sb_q.push_back(16'h0000); sb_q.push_back(16'h0003);
        y_mux = 3'd5; y_wr = 1;
        pulse();
        mdata_mux = 1; alu_op = 3'd0;
        #1;
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_y !== expv) $display("FAIL cs_y5 got=%h exp=%h", dut.r_y, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (mem_wdata !== expv) $display("FAIL cs_alu got=%h exp=%h", mem_wdata, expv); else n_pass++;
        clr_ctl();
    endtask

    task automatic test_alu_misc();
        logic [2:0]  ops [6] = '{3'd2, 3'd1, 3'd7, 3'd0, 3'd3, 3'd4};
        logic [15:0] ex  [6] = '{16'h000F, 16'h0E10, 16'h0F0F, 16'h100E, 16'h0001, 16'hFFFE};
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin set_y(16'h00FF); ld(R_X, 16'h0F0F); end
            if (i == 4) begin set_y(16'hFFFF); ld(R_X, 16'hFFFF); end
            sb_q.push_back(ex[i]);
            mdata_mux = 1; alu_op = ops[i];
            #1;
            n_tot++; expv = sb_q.pop_front();
            if (mem_wdata !== expv) $display("FAIL alu_op%0d got=%h exp=%h", ops[i], mem_wdata, expv); else n_pass++;
            clr_ctl();
        end
        sb_q.push_back(16'h0010);
        maddr_mux = 1;
        #1;
        n_tot++; expv = sb_q.pop_front();
        if ({4'd0, mem_addr} !== expv) $display("FAIL maddr_b got=%h exp=%h", mem_addr, expv); else n_pass++;
        clr_ctl();
    endtask

    task automatic test_back_to_back();
        ld(R_A, 16'h5A5A);
        sb_q.push_back(16'h6010); sb_q.push_back(16'h5A5A); sb_q.push_back(16'h5A5A);
        x_mux = 2'd2; x_wr = 1; q_mux = 2'd0; q_wr = 1;
        @(posedge clk); #1;
        clr_ctl();
        x_mux = 2'd3; x_wr = 1; q_mux = 2'd1; q_wr = 1; alu_op = 3'd7; a_mux = 2'd1;
        pulse();
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_x !== expv) $display("FAIL b2b_x got=%h exp=%h", dut.r_x, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_q !== expv) $display("FAIL b2b_q got=%h exp=%h", dut.r_q, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_a !== expv) $display("FAIL b2b_a_hold got=%h exp=%h", dut.r_a, expv); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [11:0] a;
        ld(R_A, 16'hABCD);
        a = pc[11:0];
        poke(a, 16'h7777);
        sb_q.push_back(16'h0); sb_q.push_back(16'h0); sb_q.push_back(16'h7777); sb_q.push_back(16'h0);
        reset = 1'b1; mem_wr = 1; a_mux = 2'd1; a_wr = 1; z_mux = 2'd1; z_wr = 1;
        #1;
        n_tot++; expv = sb_q.pop_front();
        if ({15'd0, mem_we} !== expv) $display("FAIL mid_mem_we got=%h exp=%h", mem_we, expv); else n_pass++;
        pulse();
        reset = 1'b0;
        n_tot++; expv = sb_q.pop_front();
        if (dut.r_a !== expv) $display("FAIL mid_a got=%h exp=%h", dut.r_a, expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (mem[a] !== expv) $display("FAIL mid_mem got=%h exp=%h", mem[a], expv); else n_pass++;
        n_tot++; expv = sb_q.pop_front();
        if (pc !== expv) $display("FAIL mid_pc got=%h exp=%h", pc, expv); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        clr_ctl();
        test_reset();
        test_tc();
        test_ad();
        test_mp_dv();
        test_xch();
        test_cs();
        test_alu_misc();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
